pq_feeder: RTL and testbench

PQ_FEEDER -- requirements
Module: pq_feeder

---
 rtl/pq_feeder.sv | 145 ++++++++++++++
 tb/tb_pq_feeder.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_feeder.sv
// Staging FIFO + command sequencer feeding a register-array priority queue.
// Optional PQ_FEEDER_STATS_EN adds saturating enq/deq/stall counters.
package pq_pkg;
    parameter int KEY_WIDTH = 8;
    parameter int VAL_WIDTH = 8;
endpackage

module pq_feeder
    import pq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PQ_CAP     = 8,
    localparam int KV_W      = KEY_WIDTH + VAL_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [KV_W-1:0] in_kv,
    output logic            in_ready,
    input  logic            deq_req,
    output logic            out_valid,
    output logic [KV_W-1:0] out_kv,
    input  logic            flush,
    output logic            busy,
    output logic            pq_enq,
    output logic            pq_deq,
    output logic [KV_W-1:0] pq_kvi,
    input  logic [KV_W-1:0] pq_kvo
`ifdef PQ_FEEDER_STATS_EN
    ,
    output logic [15:0]     enq_cnt,
    output logic [15:0]     deq_cnt,
    output logic [15:0]     stall_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(PQ_CAP + 1);

    typedef enum logic {NORMAL, FLUSH} state_t;

    state_t          state;
    logic [KV_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [CW-1:0]   cnt;
    logic [OW-1:0]   occ;
    logic            rdy_en;
    logic            deq_user;
    logic            fifo_full, fifo_empty, normal_go, push, do_enq, do_deq;

    always_comb begin
        fifo_full  = (cnt == CW'(FIFO_DEPTH));
        fifo_empty = (cnt == '0);
        in_ready   = rdy_en & ~fifo_full & (state == NORMAL);
        busy       = (state == FLUSH);
        push       = in_valid & in_ready;
        // No new commands on the flush edge; the staged entries are being dropped.
        normal_go  = (state == NORMAL) & ~flush;
        // A deq is outstanding from issue until its out_valid cycle has passed.
        do_deq     = normal_go & deq_req & (occ != '0) & ~pq_deq & ~out_valid;
        do_enq     = normal_go & ~fifo_empty & ((occ < OW'(PQ_CAP)) | do_deq);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= in_kv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= NORMAL;
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            occ       <= '0;
            rdy_en    <= 1'b0;
            deq_user  <= 1'b0;
            pq_enq    <= 1'b0;
            pq_deq    <= 1'b0;
            pq_kvi    <= '0;
            out_valid <= 1'b0;
            out_kv    <= '0;
        end else begin
            rdy_en    <= 1'b1;
            pq_enq    <= 1'b0;
            pq_deq    <= 1'b0;
            out_valid <= pq_deq & deq_user & (state == NORMAL) & ~flush;
            if (pq_deq & deq_user & (state == NORMAL) & ~flush) out_kv <= pq_kvo;
            case (state)
                NORMAL: begin
                    if (flush) begin
                        state <= FLUSH;
                        wptr  <= '0;
                        rptr  <= '0;
                        cnt   <= '0;
                    end else begin
                        if (push)   wptr <= wptr + 1'b1;
                        if (do_enq) begin
                            rptr   <= rptr + 1'b1;
                            pq_kvi <= mem[rptr];
                        end
                        cnt      <= cnt + CW'(push) - CW'(do_enq);
                        pq_enq   <= do_enq;
                        pq_deq   <= do_deq;
                        deq_user <= do_deq;
                        if (do_enq & ~do_deq)      occ <= occ + 1'b1;
                        else if (do_deq & ~do_enq) occ <= occ - 1'b1;
                    end
                end
                FLUSH: begin
                    deq_user <= 1'b0;
                    if (occ != '0) begin
                        pq_deq <= 1'b1;
                        occ    <= occ - 1'b1;
                    end else if (!pq_enq && !pq_deq) begin
                        state <= NORMAL;
                    end
                end
                default: state <= NORMAL;
            endcase
        end
    end

`ifdef PQ_FEEDER_STATS_EN
    logic iss_enq, iss_deq, stall;

    always_comb begin
        iss_enq = do_enq;
        iss_deq = do_deq | ((state == FLUSH) & (occ != '0));
        stall   = ~fifo_empty & ~do_enq;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enq_cnt   <= '0;
            deq_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (iss_enq && enq_cnt != 16'hFFFF)   enq_cnt   <= enq_cnt + 1'b1;
            if (iss_deq && deq_cnt != 16'hFFFF)   deq_cnt   <= deq_cnt + 1'b1;
            if (stall && stall_cnt != 16'hFFFF)   stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pq_feeder.sv
// Randomized bench for pq_feeder with a behavioural priority-queue model and
// a max-first expected-output list.
module tb_pq_feeder;
    import pq_pkg::*;
    localparam int KV_W = KEY_WIDTH + VAL_WIDTH;
    localparam int FD   = 4;
    localparam int CAP  = 8;

    logic            clk = 1'b0, rst_n = 1'b0;
    logic            in_valid = 1'b0, deq_req = 1'b0, flush = 1'b0;
    logic [KV_W-1:0] in_kv = '0;
    logic            in_ready, out_valid, busy, pq_enq, pq_deq;
    logic [KV_W-1:0] out_kv, pq_kvi, pq_kvo;
`ifdef PQ_FEEDER_STATS_EN
    logic [15:0]     enq_cnt, deq_cnt, stall_cnt;
`endif

    pq_feeder #(.FIFO_DEPTH(FD), .PQ_CAP(CAP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_kv(in_kv),
        .in_ready(in_ready), .deq_req(deq_req), .out_valid(out_valid),
        .out_kv(out_kv), .flush(flush), .busy(busy), .pq_enq(pq_enq),
        .pq_deq(pq_deq), .pq_kvi(pq_kvi), .pq_kvo(pq_kvo)
`ifdef PQ_FEEDER_STATS_EN
        , .enq_cnt(enq_cnt), .deq_cnt(deq_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [KV_W-1:0] acc_q[$];
    logic [KV_W-1:0] exp_q[$];

    function automatic int qmax_idx(input logic [KV_W-1:0] q[$]);
        int idx = 0;
        foreach (q[i]) if (q[i] > q[idx]) idx = i;
        return idx;
    endfunction

    // Downstream PQ model: head is the largest {key,val}; a combined command
    // removes the current head and inserts the new pair.
    logic [KV_W-1:0] pq_q[$];
    logic [KV_W-1:0] pq_head;
    logic [KV_W-1:0] enq_log[$];
    int n_enq = 0, n_deq = 0, n_comb = 0, n_outv = 0, model_err = 0;
    assign pq_kvo = pq_head;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pq_q.delete();
            pq_head <= '0;
        end else begin
            if (pq_deq) begin
                n_deq++;
                if (pq_q.size() == 0) model_err++;
                else pq_q.delete(qmax_idx(pq_q));
            end
            if (pq_enq) begin
                n_enq++;
                if (pq_q.size() >= CAP) model_err++;
                pq_q.push_back(pq_kvi);
                enq_log.push_back(pq_kvi);
            end
            if (pq_enq && pq_deq) n_comb++;
            if (out_valid) n_outv++;
            pq_head <= (pq_q.size() == 0) ? '0 : pq_q[qmax_idx(pq_q)];
        end
    end

    task automatic exp_pop(output logic [KV_W-1:0] kv);
        int idx;
        idx = qmax_idx(exp_q);
        kv = exp_q[idx];
        exp_q.delete(idx);
    endtask

    task automatic push(input logic [KV_W-1:0] kv);
        bit ok = 0;
        in_valid = 1'b1;
        in_kv = kv;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL push_accept: kv=%h never accepted", kv);
        end else begin
            acc_q.push_back(kv);
            exp_q.push_back(kv);
        end
    endtask

    task automatic deq_one(output logic [KV_W-1:0] kv, output int lat);
        kv = '0;
        lat = -1;
        deq_req = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                kv = out_kv;
                lat = i;
                break;
            end
        end
        deq_req = 1'b0;
    endtask

    task automatic deq_chk(input string nm);
        logic [KV_W-1:0] got, exp;
        int lat;
        deq_one(got, lat);
        exp_pop(exp);
        checks++;
        if (lat < 0 || got !== exp) begin
            failures++;
            $display("FAIL %s: got %h (lat %0d) expected %h", nm, got, lat, exp);
        end
    endtask

    task automatic wait_idle(input int sz);
        bit ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = (pq_q.size() == sz) && !pq_enq && !pq_deq;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_idle: pq size %0d expected %0d", pq_q.size(), sz);
        end
    endtask

    task automatic test_reset;
        #23;
        checks++;
        if ({in_ready, out_valid, busy, pq_enq, pq_deq, pq_kvi, out_kv} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {in_ready, out_valid, busy, pq_enq, pq_deq, pq_kvi, out_kv});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_ready: in_ready=%b expected 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ready_after_reset: in_ready=%b busy=%b expected 1 0", in_ready, busy);
        end
    endtask

    task automatic test_single;
        logic [KV_W-1:0] got, exp;
        int lat;
        push({8'd8, 8'd14});
        checks++;
        if (pq_enq !== 1'b0) begin
            failures++;
            $display("FAIL enq_too_early: pq_enq=%b expected 0", pq_enq);
        end
        @(negedge clk);
        checks++;
        if (pq_enq !== 1'b1 || pq_kvi !== {8'd8, 8'd14}) begin
            failures++;
            $display("FAIL enq_latency: pq_enq=%b pq_kvi=%h expected 1 080e", pq_enq, pq_kvi);
        end
        wait_idle(1);
        deq_one(got, lat);
        exp_pop(exp);
        checks++;
        if (lat != 2 || got !== exp) begin
            failures++;
            $display("FAIL deq_latency: got %h lat %0d expected %h lat 2", got, lat, exp);
        end
        wait_idle(0);
    endtask

    task automatic test_order;
        int ov0 = n_outv;
        push({8'd11, 8'd11});
        push({8'd9, 8'd9});
        push({8'd10, 8'd10});
        push({8'd8, 8'd8});
        wait_idle(4);
        for (int i = 0; i < 4; i++) deq_chk("order_deq");
        wait_idle(0);
        checks++;
        if (n_outv - ov0 != 4) begin
            failures++;
            $display("FAIL order_pulses: got %0d expected 4", n_outv - ov0);
        end
    endtask

    task automatic test_combined;
        int e0, c0, d0;
        for (int i = 0; i < CAP; i++) push({8'($urandom_range(16, 255)), 8'($urandom)});
        wait_idle(CAP);
        e0 = n_enq;
        push({8'd12, 8'd12});
        repeat (3) @(negedge clk);
        checks++;
        if (n_enq != e0) begin
            failures++;
            $display("FAIL enq_when_full: enqs %0d expected 0", n_enq - e0);
        end
        c0 = n_comb;
        d0 = n_deq;
        deq_chk("combined_deq");
        wait_idle(CAP);
        checks++;
        if (n_comb - c0 != 1 || n_deq - d0 != 1) begin
            failures++;
            $display("FAIL combined_cmd: comb %0d deq %0d expected 1 1", n_comb - c0, n_deq - d0);
        end
    endtask

    task automatic test_full_stall;
        int e0;
`ifdef PQ_FEEDER_STATS_EN
        logic [15:0] s0;
`endif
        for (int i = 0; i < FD; i++) push({8'($urandom_range(16, 255)), 8'($urandom)});
        e0 = n_enq;
`ifdef PQ_FEEDER_STATS_EN
        s0 = stall_cnt;
`endif
        repeat (5) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || n_enq != e0) begin
            failures++;
            $display("FAIL full_stall: in_ready=%b enqs %0d expected 0 0", in_ready, n_enq - e0);
        end
`ifdef PQ_FEEDER_STATS_EN
        checks++;
        if (stall_cnt - s0 != 16'd5 || enq_cnt != 16'(n_enq) || deq_cnt != 16'(n_deq)) begin
            failures++;
            $display("FAIL stats: stall+%0d enq %0d deq %0d expected 5 %0d %0d",
                     stall_cnt - s0, enq_cnt, deq_cnt, n_enq, n_deq);
        end
`endif
    endtask

    task automatic test_flush(input int k, input bit extra);
        int d0 = n_deq, e0 = n_enq, v0 = n_outv;
        bit done = 0;
        flush = 1'b1;
        deq_req = extra;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_busy: busy=%b expected 1", busy);
        end
        if (extra) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = !busy;
        end
        deq_req = 1'b0;
        checks++;
        if (!done || n_deq - d0 != k || n_outv != v0 || n_enq != e0 || pq_q.size() != 0) begin
            failures++;
            $display("FAIL flush_drain: done=%b deqs %0d outv %0d enqs %0d expected 1 %0d 0 0",
                     done, n_deq - d0, n_outv - v0, n_enq - e0, k);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_ready: in_ready=%b expected 1", in_ready);
        end
        exp_q.delete();
    endtask

    task automatic test_random;
        for (int b = 0; b < 3; b++) begin
            int n = $urandom_range(1, CAP);
            int base = enq_log.size();
            bit ord_ok = 1;
            acc_q.delete();
            for (int i = 0; i < n; i++) begin
                push(16'($urandom));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            wait_idle(n);
            for (int i = 0; i < n; i++)
                if (enq_log.size() <= base + i || enq_log[base + i] !== acc_q[i]) ord_ok = 0;
            checks++;
            if (!ord_ok) begin
                failures++;
                $display("FAIL fifo_order: batch %0d enq order differs from accept order", b);
            end
            for (int i = 0; i < n; i++) begin
                deq_chk("random_deq");
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid;
        int d0, v0;
        logic [KV_W-1:0] kv;
        bit seen = 0;
        push(16'($urandom));
        push(16'($urandom));
        wait_idle(2);
        in_valid = 1'b1;
        deq_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_kv = 16'($urandom);
            @(posedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, pq_enq, pq_deq, pq_kvi, out_kv} !== '0) begin
            failures++;
            $display("FAIL reset_mid: got %b expected all zero",
                     {in_ready, out_valid, busy, pq_enq, pq_deq, pq_kvi, out_kv});
        end
`ifdef PQ_FEEDER_STATS_EN
        checks++;
        if ({enq_cnt, deq_cnt, stall_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_stats: got %h expected 0", {enq_cnt, deq_cnt, stall_cnt});
        end
`endif
        @(negedge clk);
        in_valid = 1'b0;
        deq_req = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        d0 = n_deq;
        v0 = n_outv;
        deq_req = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (n_deq != d0 || n_outv != v0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL deq_on_empty: deqs %0d outv %0d ready %b expected 0 0 1",
                     n_deq - d0, n_outv - v0, in_ready);
        end
        kv = 16'($urandom);
        push(kv);
        for (int i = 0; i < 20 && !seen; i++) begin
            seen = out_valid;
            if (!seen) @(negedge clk);
        end
        checks++;
        if (!seen || out_kv !== kv) begin
            failures++;
            $display("FAIL deq_after_wait: seen=%b got %h expected %h", seen, out_kv, kv);
        end
        deq_req = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_order();
        test_combined();
        test_full_stall();
        test_flush(CAP, 1'b0);
        push(16'($urandom));
        push(16'($urandom));
        push(16'($urandom));
        wait_idle(3);
        test_flush(3, 1'b1);
        test_random();
        test_reset_mid();
        checks++;
        if (model_err != 0) begin
            failures++;
            $display("FAIL pq_model: %0d overflow/underflow commands expected 0", model_err);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
